// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter feeding a shared combinational ALU through a two-stage pipeline.
// Optional build macro ALU_ARB_FIXED_PRIO_EN: port 0 always wins contention and the priority pointer is removed.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CTLW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid0,
  input  logic             req_valid1,
  output logic             req_ready0,
  output logic             req_ready1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [CTLW-1:0]  req_ctl0,
  input  logic [CTLW-1:0]  req_ctl1,
  output logic             resp_valid0,
  output logic             resp_valid1,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [CTLW-1:0]  alu_ctl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  logic             grant0_s;
  logic             grant1_s;
  logic             accept_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic [CTLW-1:0]  sel_ctl_s;
  logic             s1_valid_r;
  logic             s1_port_r;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic             prio_r;
`endif

  // Grant selection: one-hot or zero, held off while reset is asserted.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (reset) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (req_valid0 && req_valid1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant0_s = 1'b1;
      grant1_s = 1'b0;
`else
      grant0_s = ~prio_r;
      grant1_s = prio_r;
`endif
    end else begin
      grant0_s = req_valid0;
      grant1_s = req_valid1;
    end
  end

  assign req_ready0 = grant0_s;
  assign req_ready1 = grant1_s;
  assign accept_s   = grant0_s | grant1_s;

  // Operand mux for the winning port.
  always_comb begin
    sel_a_s   = {WIDTH{1'b0}};
    sel_b_s   = {WIDTH{1'b0}};
    sel_ctl_s = {CTLW{1'b0}};
    case ({grant1_s, grant0_s})
      2'b01: begin
        sel_a_s   = req_a0;
        sel_b_s   = req_b0;
        sel_ctl_s = req_ctl0;
      end
      2'b10: begin
        sel_a_s   = req_a1;
        sel_b_s   = req_b1;
        sel_ctl_s = req_ctl1;
      end
      default: begin
        sel_a_s   = alu_a;
        sel_b_s   = alu_b;
        sel_ctl_s = alu_ctl;
      end
    endcase
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Round-robin pointer: favour the other port after every grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_r <= 1'b0;
    end else if (accept_s) begin
      prio_r <= grant0_s;
    end else begin
      prio_r <= prio_r;
    end
  end
`endif

  // Issue stage: ALU inputs only change on accept so they stay quiet when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a      <= {WIDTH{1'b0}};
      alu_b      <= {WIDTH{1'b0}};
      alu_ctl    <= {CTLW{1'b0}};
      s1_valid_r <= 1'b0;
      s1_port_r  <= 1'b0;
    end else if (accept_s) begin
      alu_a      <= sel_a_s;
      alu_b      <= sel_b_s;
      alu_ctl    <= sel_ctl_s;
      s1_valid_r <= 1'b1;
      s1_port_r  <= grant1_s;
    end else begin
      s1_valid_r <= 1'b0;
    end
  end

  // Capture stage: one-cycle response pulse to the port that issued the op.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_result <= {WIDTH{1'b0}};
      resp_zero   <= 1'b0;
      resp_valid0 <= 1'b0;
      resp_valid1 <= 1'b0;
    end else if (s1_valid_r) begin
      resp_result <= alu_result;
      resp_zero   <= alu_zero;
      resp_valid0 <= ~s1_port_r;
      resp_valid1 <= s1_port_r;
    end else begin
      resp_valid0 <= 1'b0;
      resp_valid1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural MIPS ALU closes the loop, expected
// responses are queued at accept time and compared when the response slot arrives.
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam int CTLW  = 4;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid0, req_valid1, req_ready0, req_ready1;
  logic [WIDTH-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [CTLW-1:0]  req_ctl0, req_ctl1;
  logic             resp_valid0, resp_valid1, resp_zero;
  logic [WIDTH-1:0] resp_result, alu_a, alu_b, alu_result;
  logic [CTLW-1:0]  alu_ctl;
  logic             alu_zero;

  typedef struct packed {
    logic        port;
    logic [31:0] res;
    logic        zero;
    logic [31:0] due;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   edge_n = 0;
  logic mprio = 1'b0;
  int   gp;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    case (c)
      4'b0000: alu_f = a & b;
      4'b0001: alu_f = a | b;
      4'b0010: alu_f = a + b;
      4'b0110: alu_f = a - b;
      4'b0111: alu_f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: alu_f = ~(a | b);
      default: alu_f = 32'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_ctl);
  assign alu_zero   = (alu_result == 32'd0);

  alu_arbiter #(.WIDTH(WIDTH), .CTLW(CTLW)) dut (
    .clk(clk), .reset(reset),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_ctl0(req_ctl0), .req_ctl1(req_ctl1),
    .resp_valid0(resp_valid0), .resp_valid1(resp_valid1),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // One clock cycle: drive, check grants, push on accept, then check the response slot.
  task automatic step(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
                      input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1,
                      output int port);
    logic g0, g1, ev0, ev1;
    logic [31:0] r;
    exp_t e;
    req_valid0 = v0; req_a0 = a0; req_b0 = b0; req_ctl0 = c0;
    req_valid1 = v1; req_a1 = a1; req_b1 = b1; req_ctl1 = c1;
    #1;
    if (reset) begin
      g0 = 1'b0; g1 = 1'b0;
    end else if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      g0 = 1'b1; g1 = 1'b0;
`else
      g0 = ~mprio; g1 = mprio;
`endif
    end else begin
      g0 = v0; g1 = v1;
    end
    check("ready0", req_ready0, g0);
    check("ready1", req_ready1, g1);
    @(posedge clk);
    edge_n++;
    port = -1;
    if (reset) begin
      q.delete();
      mprio = 1'b0;
    end else if (g0 || g1) begin
      r = g0 ? alu_f(a0, b0, c0) : alu_f(a1, b1, c1);
      e.port = g1; e.res = r; e.zero = (r == 32'd0); e.due = edge_n + 1;
      q.push_back(e);
      mprio = g0;
      port = g1 ? 1 : 0;
    end
    @(negedge clk);
    ev0 = 1'b0; ev1 = 1'b0;
    if (q.size() > 0 && q[0].due == edge_n) begin
      e = q.pop_front();
      ev0 = ~e.port; ev1 = e.port;
      check("resp_valid0", resp_valid0, ev0);
      check("resp_valid1", resp_valid1, ev1);
      check("resp_result", resp_result, e.res);
      check("resp_zero", resp_zero, e.zero);
    end else begin
      check("resp_valid0", resp_valid0, ev0);
      check("resp_valid1", resp_valid1, ev1);
    end
  endtask

  task automatic idle(input int n);
    int p;
    for (int k = 0; k < n; k++) step(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, p);
  endtask

  initial begin
    reset = 1'b1;
    // Reset with both ports requesting: no grants, everything cleared.
    for (int k = 0; k < 2; k++) step(1'b1, 32'd1, 32'd2, OP_ADD, 1'b1, 32'd3, 32'd4, OP_ADD, gp);
    check("rst_alu_a", alu_a, 64'd0);
    check("rst_alu_b", alu_b, 64'd0);
    check("rst_alu_ctl", alu_ctl, 64'd0);
    check("rst_result", resp_result, 64'd0);
    check("rst_zero", resp_zero, 64'd0);
    reset = 1'b0;

    // Contention: port 0 first, then alternation (or always port 0 in fixed build).
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'(100 + i), 32'd3, OP_ADD, 1'b1, 32'(50 + i), 32'(10 + i), OP_SUB, gp);
`ifdef ALU_ARB_FIXED_PRIO_EN
      check("cont_port", gp, 64'd0);
`else
      check("cont_port", gp, 64'(i % 2));
`endif
    end
    idle(2);

    // Single op on port 0: 5 + 7.
    step(1'b1, 32'd5, 32'd7, OP_ADD, 1'b0, 32'd0, 32'd0, 4'd0, gp);
    check("single_port", gp, 64'd0);
    check("single_alu_a", alu_a, 64'd5);
    check("single_alu_b", alu_b, 64'd7);
    check("single_alu_ctl", alu_ctl, 64'(OP_ADD));
    idle(1);
    check("single_result", resp_result, 64'd12);
    idle(1);

    // Zero flag on port 1.
    step(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'h1234, 32'h1234, OP_SUB, gp);
    check("zero_port", gp, 64'd1);
    idle(1);
    check("zero_flag", resp_zero, 64'd1);
    idle(1);

    // Streaming on port 1: eight back-to-back ops, responses every cycle.
    for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'(i), 32'd1, OP_ADD, gp);
    check("stream_last", resp_result, 64'd7);
    idle(2);
    check("stream_drained", q.size(), 64'd0);

    // Reset mid-op: request discarded, result register cleared.
    step(1'b1, 32'd9, 32'd9, OP_ADD, 1'b0, 32'd0, 32'd0, 4'd0, gp);
    reset = 1'b1;
    idle(1);
    check("midrst_result", resp_result, 64'd0);
    check("midrst_zero", resp_zero, 64'd0);
    reset = 1'b0;
    idle(3);

    // After reset port 0 wins contention again.
    step(1'b1, 32'd2, 32'd2, OP_ADD, 1'b1, 32'd8, 32'd1, OP_SUB, gp);
    check("post_rst_port", gp, 64'd0);
    idle(3);
    check("final_drained", q.size(), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter that shares the single-cycle combinational `ALU` between two requesters (e.g. the main datapath and the branch/address unit) in the CECS341 MIPS core. It accepts operand/control triples over valid/ready handshakes, registers the winning request onto the ALU inputs, and captures the ALU result and zero flag one cycle later. The captured values are returned to the originating port as a one-cycle response pulse. It is fully pipelined, so one operation is accepted per cycle.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width
- `CTLW`, 4, ALU control width

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `req_valid0` / `req_valid1`  in  1  request present on port 0 / 1
- `req_ready0` / `req_ready1`  out  1  grant; the request is accepted when valid&ready at a clock edge
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  WIDTH  operands per port
- `req_ctl0`, `req_ctl1`  in  CTLW  ALU control code per port
- `resp_valid0` / `resp_valid1`  out  1  one-cycle result pulse to port 0 / 1
- `resp_result`  out  WIDTH  captured ALU result, shared by both ports
- `resp_zero`  out  1  captured ALU zero flag
- `alu_a`, `alu_b`  out  WIDTH  registered operands driven to the ALU
- `alu_ctl`  out  CTLW  registered control code driven to the ALU
- `alu_result`  in  WIDTH  ALU output, combinational from `alu_*`
- `alu_zero`  in  1  ALU zero flag

## Operation
- **Grant logic** (combinational):
  - Grant is one-hot or zero.
  - Only one requester valid: that requester is granted.
  - Both requesters valid: the port indicated by priority pointer `prio` is granted.
  - `req_readyN` = grant to port N. Ready may depend on valid; requesters must not depend on ready to assert valid.
- **Round robin:** after a granted transfer to port N, `prio` becomes 1−N. `prio` does not change on cycles with no grant.
- **Issue stage (S1):**
  - On accept, the granted operands and ctl are registered into `alu_a`/`alu_b`/`alu_ctl`.
  - `s1_valid` is set to 1 and `s1_port` to N.
  - With no accept, `s1_valid` is set to 0. `alu_*` keep their last values, so they do not toggle.
- **Capture stage (S2):**
  - If `s1_valid`, `alu_result`/`alu_zero` are registered into `resp_result`/`resp_zero`, and `resp_valid[s1_port]` is 1 for exactly one cycle.
  - Otherwise both `resp_valid` are 0 and `resp_result`/`resp_zero` hold.
- **Backpressure:** responses have none. Requesters must sample on the `resp_valid` pulse.
- **Simultaneous events:** an accept and a capture in the same cycle are independent. Back-to-back accepts from alternating or same ports stream at 1 op/cycle.
- **Reset mid-operation:** in-flight S1/S2 contents are discarded and no response is issued for them. Requesters must re-issue.

## Timing
- Reset values:
  - `alu_a` = `alu_b` = 0, `alu_ctl` = 0
  - `resp_result` = 0, `resp_zero` = 0, `resp_valid0/1` = 0
  - `s1_valid` = 0, `prio` = 0 (port 0 favoured)
- `req_ready0/1` are combinational and are 0 whenever the corresponding valid is 0.
- Latency: request accepted at edge E0 → `alu_*` valid after E0 → `resp_valid` high during the cycle after E1 (2 edges).
- Throughput: one accept per cycle. With both ports continuously valid, grants alternate 0,1,0,1…
- The first response after reset is at least 2 cycles after reset deassertion.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`:
  - **Defined:** port 0 always wins contention, and `prio` is removed (port 1 may starve).
  - **Undefined (default):** round-robin as described above.
- All other behaviour, including latency and reset values, is identical in both builds.

## Test plan
- **Reset:** assert `reset` 2 cycles with both valids high → all outputs 0, `req_ready0/1` = 0 during reset. After release, port 0 is granted first.
- **Single op:** port 0 requests a=5, b=7, ctl=ADD (0010) for one cycle; the bench model returns a+b.
  - `alu_a`=5, `alu_b`=7 after E0.
  - `resp_valid0`=1, `resp_result`=12, `resp_zero`=0 after E1.
  - `resp_valid1` stays 0.
- **Zero flag:** port 1 requests SUB with a=b=0x1234 → `resp_valid1` pulse with `resp_result`=0, `resp_zero`=1.
- **Contention:** both ports valid for 4 cycles with distinct operands.
  - Round-robin build: grants 0,1,0,1 and responses alternate 2 cycles later with the matching results.
  - Fixed-priority build: grants 0,0,0,0.
- **Streaming:** port 1 alone valid for 8 consecutive cycles with a=i, b=1 → 8 consecutive `resp_valid1` pulses with results i+1, no bubbles.
- **Reset mid-op:** accept a request, then assert `reset` at E1 → no response pulse for it, and `resp_result` = 0.
